// File: rtl/alu_mul_seq.sv
// Shift-add RV64 MUL sequencer: borrows the execute-stage ALU's ADD each cycle and
// accumulates partial products, returning the low WIDTH bits of the product.
module alu_mul_seq #(
    parameter int unsigned WIDTH   = 64,
    parameter logic [3:0]  ADD_OP  = 4'b0010,
    parameter logic [3:0]  IDLE_OP = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_acc_q, w_acc_d;
    logic [WIDTH-1:0] r_m_q, w_m_d;
    logic [WIDTH-1:0] r_q_q, w_q_d;
    logic [WIDTH-1:0] w_q_shr;

    assign w_q_shr = r_q_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= StIdle;
            r_acc_q   <= '0;
            r_m_q     <= '0;
            r_q_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_m_q     <= w_m_d;
            r_q_q     <= w_q_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_m_d     = r_m_q;
        w_q_d     = r_q_q;
        // A flush aborts from any state; datapath registers are left as-is.
        if (flush) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state_q)
                StIdle: begin
                    if (in_valid) begin
                        w_acc_d   = '0;
                        w_m_d     = in_a;
                        w_q_d     = in_b;
                        w_state_d = (in_b == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (r_q_q[0]) begin
                        w_acc_d = alu_res;
                    end
                    w_m_d = r_m_q << 1;
                    w_q_d = w_q_shr;
                    if (w_q_shr == '0) begin
                        w_state_d = StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state_q == StIdle);
        res_valid = (r_state_q == StDone);
        busy      = (r_state_q != StIdle);
        res       = r_acc_q;
        alu_a     = r_acc_q;
        alu_b     = r_m_q;
        alu_op    = (r_state_q == StRun) ? ADD_OP : IDLE_OP;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the ALU, drives directed and random multiplies and
// compares against plain a*b arithmetic and a latency derived from the multiplier's MSB.
module tb_alu_mul_seq;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         flush;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res;
    logic         busy;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_res;

    int n_asserts;
    int n_fail;

    alu_mul_seq #(
        .WIDTH  (W),
        .ADD_OP (4'b0010),
        .IDLE_OP(4'b0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .flush    (flush),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res      (res),
        .busy     (busy),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res)
    );

    // Behavioural ALU: ADD for 0010, AND otherwise.
    assign alu_res = (alu_op == 4'b0010) ? (alu_a + alu_b) : (alu_a & alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
        int msb;
        msb = -1;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return (msb < 0) ? 1 : msb + 2;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, W'(in_ready), W'(1));
        chk({tag, "_res_valid"}, W'(res_valid), W'(0));
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_alu_op"}, W'(alu_op), W'(4'b0000));
    endtask

    // Issue one multiply, follow it to completion, hold DONE for 'stall' cycles.
    task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall);
        logic [W-1:0] prod;
        int           cyc;
        int           bad_op;
        prod = a * b;
        @(negedge clk);
        chk({tag, "_ready_before"}, W'(in_ready), W'(1));
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        cyc      = 1;
        bad_op   = 0;
        while (!res_valid && cyc < 80) begin
            if (alu_op !== 4'b0010 || busy !== 1'b1 || in_ready !== 1'b0) bad_op++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_run_outputs"}, W'(bad_op), W'(0));
        chk({tag, "_latency"}, W'(cyc), W'(exp_latency(b)));
        chk({tag, "_res"}, res, prod);
        chk({tag, "_done_ready"}, W'(in_ready), W'(0));
        chk({tag, "_done_alu_op"}, W'(alu_op), W'(4'b0000));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, W'(res_valid), W'(1));
            chk({tag, "_stall_res"}, res, prod);
            chk({tag, "_stall_ready"}, W'(in_ready), W'(0));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_idle({tag, "_after"});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_asserts = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_res", res, '0);
        chk("reset_alu_a", alu_a, '0);
        chk("reset_alu_b", alu_b, '0);
        rst_n = 1'b1;

        do_mul("m3x5", 64'd3, 64'd5, 0);
        do_mul("bzero", 64'h1234, 64'd0, 0);
        do_mul("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
        do_mul("msb63", 64'd1, 64'h8000_0000_0000_0000, 0);
        do_mul("stall", 64'd11, 64'd13, 10);

        // Flush together with in_valid in IDLE: nothing accepted.
        @(negedge clk);
        in_a     = 64'd5;
        in_b     = 64'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_idle("flush_idle");

        // Flush on the third RUN cycle of 7*0xFF.
        in_a     = 64'd7;
        in_b     = 64'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_run_busy", W'(busy), W'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle("flush_run");
        repeat (10) @(negedge clk);
        chk("flush_no_result", W'(res_valid), W'(0));
        do_mul("post_flush", 64'd6, 64'd7, 0);

        // Flush together with res_ready in DONE drops the result.
        @(negedge clk);
        in_a     = 64'd9;
        in_b     = 64'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_done_valid", W'(res_valid), W'(1));
        flush     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        res_ready = 1'b0;
        check_idle("flush_done");

        // Asynchronous reset mid-RUN.
        in_a     = 64'h1234_5678;
        in_b     = 64'hFFFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        chk("async_reset_res", res, '0);
        chk("async_reset_alu_a", alu_a, '0);
        chk("async_reset_alu_b", alu_b, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_mul("post_reset", 64'd2, 64'd9, 0);

        for (int i = 0; i < 25; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) rb = '0;
            do_mul("rand", ra, rb, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
